// File: rtl/butterfly_array.sv
// butterfly_array: B-lane pipelined radix-2 DIT butterflies (c = a + w*b, d = a - w*b); define BUTTERFLY_ARRAY_SCALE_EN to halve S2 outputs
module butterfly_array #(
  parameter int N = 32,
  parameter int D = 16,
  parameter int B = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           recv_val,
  output logic           recv_rdy,
  input  logic           inv,
  input  logic [B*N-1:0] ar,
  input  logic [B*N-1:0] ac,
  input  logic [B*N-1:0] br,
  input  logic [B*N-1:0] bc,
  input  logic [B*N-1:0] wr,
  input  logic [B*N-1:0] wc,
  output logic           send_val,
  input  logic           send_rdy,
  output logic [B*N-1:0] cr,
  output logic [B*N-1:0] cc,
  output logic [B*N-1:0] dr,
  output logic [B*N-1:0] dc
);
  logic           s1_val, s2_val, s2_load, fire;
  logic [B*N-1:0] s1_ar, s1_ac, s1_tr, s1_tc;
  logic [B*N-1:0] t_r_n, t_c_n, cr_n, cc_n, dr_n, dc_n;
  assign s2_load  = ~s2_val | send_rdy;
  assign recv_rdy = ~s1_val | s2_load;
  assign fire     = recv_val & recv_rdy;
  assign send_val = s2_val;
  for (genvar k = 0; k < B; k++) begin : g_lane
    logic signed [N-1:0]   lb_r, lb_c, lw_r, lw_c, sa_r, sa_c, st_r, st_c;
    logic signed [2*N-1:0] p_r, p_c;
    assign lb_r = br[k*N +: N];
    assign lb_c = bc[k*N +: N];
    assign lw_r = wr[k*N +: N];
    assign lw_c = inv ? -wc[k*N +: N] : wc[k*N +: N];
    assign p_r  = (2*N)'(lb_r) * (2*N)'(lw_r) - (2*N)'(lb_c) * (2*N)'(lw_c);
    assign p_c  = (2*N)'(lb_r) * (2*N)'(lw_c) + (2*N)'(lb_c) * (2*N)'(lw_r);
    assign t_r_n[k*N +: N] = N'(p_r >>> D);
    assign t_c_n[k*N +: N] = N'(p_c >>> D);
    assign sa_r = s1_ar[k*N +: N];
    assign sa_c = s1_ac[k*N +: N];
    assign st_r = s1_tr[k*N +: N];
    assign st_c = s1_tc[k*N +: N];
`ifdef BUTTERFLY_ARRAY_SCALE_EN
    assign cr_n[k*N +: N] = N'(((N+1)'(sa_r) + (N+1)'(st_r)) >>> 1);
    assign cc_n[k*N +: N] = N'(((N+1)'(sa_c) + (N+1)'(st_c)) >>> 1);
    assign dr_n[k*N +: N] = N'(((N+1)'(sa_r) - (N+1)'(st_r)) >>> 1);
    assign dc_n[k*N +: N] = N'(((N+1)'(sa_c) - (N+1)'(st_c)) >>> 1);
`else
    assign cr_n[k*N +: N] = sa_r + st_r;
    assign cc_n[k*N +: N] = sa_c + st_c;
    assign dr_n[k*N +: N] = sa_r - st_r;
    assign dc_n[k*N +: N] = sa_c - st_c;
`endif
  end
  // S1 captures a and the twiddled b on input fire; S2 captures butterfly results whenever it can load
  always_ff @(posedge clk)
    if (reset) begin
      s1_val <= 1'b0;
      s2_val <= 1'b0;
      s1_ar  <= '0;
      s1_ac  <= '0;
      s1_tr  <= '0;
      s1_tc  <= '0;
      cr     <= '0;
      cc     <= '0;
      dr     <= '0;
      dc     <= '0;
    end else begin
      if (fire) begin
        s1_ar <= ar;
        s1_ac <= ac;
        s1_tr <= t_r_n;
        s1_tc <= t_c_n;
      end
      s1_val <= fire | (s1_val & ~s2_load);
      if (s2_load) s2_val <= s1_val;
      if (s2_load & s1_val) begin
        cr <= cr_n;
        cc <= cc_n;
        dr <= dr_n;
        dc <= dc_n;
      end
    end
endmodule
